// File: rtl/axi4_rd_arbiter_pkg.sv
// Shared types and constants for the AXI4 read-channel arbiter slice.
package axi4_arb_pkg;

    localparam int NM_MAX     = 4;
    localparam int BEAT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi4_rd_arbiter_if.sv
// Bundle of the NM-master read address/data channels and the single slave port.
// Valid/ready rule on every channel: a transfer happens on a rising edge where
// both valid and ready are high; the sender holds payload stable until then.
interface axi4_rd_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int NM             = 2
);
    logic [NM*AXI_ADDR_WIDTH-1:0] m_araddr;
    logic [NM*AXI_ID_WIDTH-1:0]   m_arid;
    logic [NM*8-1:0]              m_arlen;
    logic [NM-1:0]                m_arvalid;
    logic [NM-1:0]                m_arready;
    logic [AXI_DATA_WIDTH-1:0]    m_rdata;
    logic [AXI_ID_WIDTH-1:0]      m_rid;
    logic [1:0]                   m_rresp;
    logic                         m_rlast;
    logic [NM-1:0]                m_rvalid;
    logic [NM-1:0]                m_rready;

    logic [AXI_ADDR_WIDTH-1:0]    s_araddr;
    logic [AXI_ID_WIDTH-1:0]      s_arid;
    logic [7:0]                   s_arlen;
    logic                         s_arvalid;
    logic                         s_arready;
    logic [AXI_DATA_WIDTH-1:0]    s_rdata;
    logic [AXI_ID_WIDTH-1:0]      s_rid;
    logic [1:0]                   s_rresp;
    logic                         s_rlast;
    logic                         s_rvalid;
    logic                         s_rready;

    // slave: the arbiter's view; master: the surrounding masters plus memory slave
    modport slave (
        input  m_araddr, m_arid, m_arlen, m_arvalid, m_rready,
        input  s_arready, s_rdata, s_rid, s_rresp, s_rlast, s_rvalid,
        output m_arready, m_rdata, m_rid, m_rresp, m_rlast, m_rvalid,
        output s_araddr, s_arid, s_arlen, s_arvalid, s_rready
    );

    modport master (
        output m_araddr, m_arid, m_arlen, m_arvalid, m_rready,
        output s_arready, s_rdata, s_rid, s_rresp, s_rlast, s_rvalid,
        input  m_arready, m_rdata, m_rid, m_rresp, m_rlast, m_rvalid,
        input  s_araddr, s_arid, s_arlen, s_arvalid, s_rready
    );
endinterface

// File: rtl/axi4_rd_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int NM    = 2,
    parameter int IDX_W = 1
) (
    input  logic [NM-1:0]    req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             gnt_valid_o
);
    int               cand;
    logic [IDX_W-1:0] idx;

    always_comb begin
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = 0;
        idx         = '0;
        for (int i = 0; i < NM_MAX; i++) begin
            if (i < NM) begin
                cand = int'(ptr_i) + i;
                if (cand >= NM) cand = cand - NM;
                idx = cand[IDX_W-1:0];
                if (!gnt_valid_o && req_i[idx]) begin
                    gnt_valid_o = 1'b1;
                    gnt_idx_o   = idx;
                end
            end
        end
    end
endmodule

// File: rtl/axi4_rd_arbiter.sv
// NM-to-1 AXI4 read arbiter: one burst outstanding, round-robin grant,
// registered address channel, zero-latency read data routing to the owner.
module axi4_rd_arbiter
    import axi4_arb_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int NM             = 2
) (
    input  logic             sys_clk_i,
    input  logic             resetn_i,
    axi4_rd_arbiter_if.slave bus_if,
    output logic             err_o,
    output arb_state_e       state_o
);
    localparam int IDX_W = (NM > 1) ? $clog2(NM) : 1;

    arb_state_e                state_q;
    logic [IDX_W-1:0]          grant_q;
    logic [IDX_W-1:0]          rr_ptr_q;
    logic [IDX_W-1:0]          rr_ptr_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [7:0]                len_q;
    logic [BEAT_CNT_W-1:0]     cnt_q;
    logic                      err_q;
    logic [IDX_W-1:0]          gnt_idx;
    logic                      gnt_valid;
    logic                      rready;
    logic                      beat;

    rr_arbiter #(
        .NM    (NM),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i       (bus_if.m_arvalid),
        .ptr_i       (rr_ptr_q),
        .gnt_idx_o   (gnt_idx),
        .gnt_valid_o (gnt_valid)
    );

    assign rr_ptr_d = (grant_q == IDX_W'(NM - 1)) ? '0 : grant_q + 1'b1;
    assign rready   = (state_q == ST_DATA) && bus_if.m_rready[grant_q];
    assign beat     = bus_if.s_rvalid && rready;

    // Fields are captured at grant so the slave sees them stable through ADDR
    // even if the master changes its own copy meanwhile.
    always_ff @(posedge sys_clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        grant_q <= gnt_idx;
                        addr_q  <= bus_if.m_araddr[int'(gnt_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        id_q    <= bus_if.m_arid[int'(gnt_idx)*AXI_ID_WIDTH +: AXI_ID_WIDTH];
                        len_q   <= bus_if.m_arlen[int'(gnt_idx)*8 +: 8];
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (bus_if.s_arready) begin
                        cnt_q   <= len_q;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        // rlast must coincide exactly with the counter reaching zero
                        if (bus_if.s_rlast != (cnt_q == '0)) err_q <= 1'b1;
                        if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                        if (bus_if.s_rlast) begin
                            state_q  <= ST_IDLE;
                            rr_ptr_q <= rr_ptr_d;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus_if.m_arready = '0;
        bus_if.m_rvalid  = '0;
        if (state_q == ST_ADDR) bus_if.m_arready[grant_q] = bus_if.s_arready;
        if (state_q == ST_DATA) bus_if.m_rvalid[grant_q]  = bus_if.s_rvalid;
    end

    assign bus_if.s_arvalid = (state_q == ST_ADDR);
    assign bus_if.s_araddr  = addr_q;
    assign bus_if.s_arid    = id_q;
    assign bus_if.s_arlen   = len_q;
    assign bus_if.s_rready  = rready;

    assign bus_if.m_rdata   = bus_if.s_rdata;
    assign bus_if.m_rid     = bus_if.s_rid;
    assign bus_if.m_rresp   = bus_if.s_rresp;
    assign bus_if.m_rlast   = bus_if.s_rlast;

    assign err_o   = err_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Scoreboarded bench for axi4_rd_arbiter: directed bursts, monitors pop expected queues.
module tb_axi4_rd_arbiter;
    import axi4_arb_pkg::*;

    localparam int AW    = 64;
    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int NM    = 2;
    localparam int EAR_W = NM + AW + IW + 8;
    localparam int ER_W  = NM + DW + IW + 2 + 1;

    logic       sys_clk_i = 1'b0;
    logic       resetn_i  = 1'b1;
    logic       err_o;
    arb_state_e state_o;

    axi4_rd_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .NM(NM)) bus ();

    axi4_rd_arbiter #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .NM(NM)) dut (
        .sys_clk_i (sys_clk_i),
        .resetn_i  (resetn_i),
        .bus_if    (bus),
        .err_o     (err_o),
        .state_o   (state_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // ---------------- master-side drive ----------------
    logic [AW-1:0] req_addr [NM];
    logic [IW-1:0] req_id   [NM];
    logic [7:0]    req_len  [NM];
    logic [NM-1:0] req_valid;
    logic [NM-1:0] rready;

    for (genvar k = 0; k < NM; k++) begin : g_pack
        assign bus.m_araddr[k*AW +: AW] = req_addr[k];
        assign bus.m_arid[k*IW +: IW]   = req_id[k];
        assign bus.m_arlen[k*8 +: 8]    = req_len[k];
    end
    assign bus.m_arvalid = req_valid;
    assign bus.m_rready  = rready;

    // ---------------- scoreboard state ----------------
    logic [EAR_W-1:0] exp_ar_q [$];
    logic [ER_W-1:0]  exp_r_q  [$];
    logic [AW-1:0]    sl_addr_q [$];
    logic [IW-1:0]    sl_id_q   [$];
    logic [7:0]       sl_len_q  [$];
    logic [EAR_W-1:0] e_ar;
    logic [ER_W-1:0]  e_r;
    int n_vec   = 0;
    int n_bad   = 0;
    int r_beats = 0;
    int early_last = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_burst(input int m, input logic [AW-1:0] a, input logic [IW-1:0] id,
                                input logic [7:0] len, input int nbeats);
        logic [NM-1:0] oh;
        oh = '0;
        oh[m] = 1'b1;
        exp_ar_q.push_back({oh, a, id, len});
        for (int b = 0; b < nbeats; b++)
            exp_r_q.push_back({oh, a[DW-1:0] + DW'(b), id, 2'(b), (b == nbeats - 1)});
    endtask

    task automatic master_req(input int m, input logic [AW-1:0] a, input logic [IW-1:0] id,
                              input logic [7:0] len);
        bit got;
        got = 1'b0;
        req_addr[m] = a;
        req_id[m]   = id;
        req_len[m]  = len;
        req_valid[m] = 1'b1;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge sys_clk_i);
            got = bus.m_arready[m];
        end
        if (!got) check("arready_timeout", 0, 1);
        @(posedge sys_clk_i);
        #1 req_valid[m] = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge sys_clk_i);
            done = (exp_ar_q.size() == 0) && (exp_r_q.size() == 0) && !bus.s_rvalid;
        end
        check({name, "_drain"}, done, 1);
        repeat (2) @(negedge sys_clk_i);
    endtask

    // ---------------- monitors ----------------
    always @(negedge sys_clk_i) begin
        if (resetn_i && bus.s_arvalid && bus.s_arready) begin
            if (exp_ar_q.size() == 0) check("ar_unexpected", 1, 0);
            else begin
                e_ar = exp_ar_q.pop_front();
                check("ar_handshake", {bus.m_arready, bus.s_araddr, bus.s_arid, bus.s_arlen}, e_ar);
            end
            sl_addr_q.push_back(bus.s_araddr);
            sl_id_q.push_back(bus.s_arid);
            sl_len_q.push_back(bus.s_arlen);
        end
    end

    always @(negedge sys_clk_i) begin
        if (resetn_i && bus.s_rvalid && bus.s_rready) begin
            r_beats++;
            if (exp_r_q.size() == 0) check("r_unexpected", 1, 0);
            else begin
                e_r = exp_r_q.pop_front();
                check("r_beat", {bus.m_rvalid, bus.m_rdata, bus.m_rid, bus.m_rresp, bus.m_rlast}, e_r);
            end
        end
    end

    // ---------------- memory slave model ----------------
    initial begin : slave_r
        logic [AW-1:0] a;
        logic [IW-1:0] id;
        logic [7:0]    len;
        bit ok, abort, done;
        bus.s_rvalid = 1'b0;
        bus.s_rdata  = '0;
        bus.s_rid    = '0;
        bus.s_rresp  = '0;
        bus.s_rlast  = 1'b0;
        forever begin
            @(posedge sys_clk_i);
            if (resetn_i && sl_addr_q.size() > 0) begin
                a = sl_addr_q.pop_front();
                id = sl_id_q.pop_front();
                len = sl_len_q.pop_front();
                abort = 1'b0;
                done  = 1'b0;
                for (int b = 0; b <= int'(len) && !done && !abort; b++) begin
                    #1;
                    bus.s_rvalid = 1'b1;
                    bus.s_rdata  = a[DW-1:0] + DW'(b);
                    bus.s_rid    = id;
                    bus.s_rresp  = 2'(b);
                    bus.s_rlast  = (b == int'(len)) || (b == early_last);
                    ok = 1'b0;
                    for (int c = 0; c < 64 && !ok && resetn_i; c++) begin
                        @(negedge sys_clk_i);
                        ok = resetn_i && bus.s_rready;
                    end
                    if (ok) @(posedge sys_clk_i);
                    if (!resetn_i) abort = 1'b1;
                    else if (!ok) begin
                        check("r_accept_timeout", 0, 1);
                        abort = 1'b1;
                    end else done = bus.s_rlast;
                end
                if (abort && !resetn_i) begin
                    // keep presenting the stale beat across and just after reset
                    for (int c = 0; c < 200 && !resetn_i; c++) @(negedge sys_clk_i);
                    repeat (2) @(negedge sys_clk_i);
                    sl_addr_q.delete();
                    sl_id_q.delete();
                    sl_len_q.delete();
                end else #1;
                bus.s_rvalid = 1'b0;
                bus.s_rlast  = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin : main
        int bad, beats, gap, base;
        bit seen;
        req_valid = '0;
        rready    = '1;
        for (int k = 0; k < NM; k++) begin
            req_addr[k] = '0;
            req_id[k]   = '0;
            req_len[k]  = '0;
        end
        bus.s_arready = 1'b1;

        #2 resetn_i = 1'b0;
        repeat (3) @(negedge sys_clk_i);
        check("rst_s_arvalid", bus.s_arvalid, 0);
        check("rst_s_rready", bus.s_rready, 0);
        check("rst_m_arready", bus.m_arready, 0);
        check("rst_m_rvalid", bus.m_rvalid, 0);
        check("rst_err", err_o, 0);
        check("rst_state", state_o, ST_IDLE);
        resetn_i = 1'b1;
        repeat (2) @(negedge sys_clk_i);

        // simultaneous pairs from reset: 0,1 then 0,1 again
        expect_burst(0, 64'h1000, 4'h1, 8'd1, 2);
        expect_burst(1, 64'h1100, 4'h2, 8'd2, 3);
        fork
            master_req(0, 64'h1000, 4'h1, 8'd1);
            master_req(1, 64'h1100, 4'h2, 8'd2);
        join
        wait_done("t039a");
        expect_burst(0, 64'h1200, 4'h3, 8'd0, 1);
        expect_burst(1, 64'h1300, 4'h4, 8'd1, 2);
        fork
            master_req(0, 64'h1200, 4'h3, 8'd0);
            master_req(1, 64'h1300, 4'h4, 8'd1);
        join
        wait_done("t039b");

        // master 1 waits through a long master 0 burst
        expect_burst(0, 64'h2000, 4'h2, 8'd7, 8);
        expect_burst(1, 64'h2800, 4'h3, 8'd0, 1);
        bad = 0;
        gap = -1;
        seen = 1'b0;
        fork
            master_req(0, 64'h2000, 4'h2, 8'd7);
            master_req(1, 64'h2800, 4'h3, 8'd0);
            begin
                for (int c = 0; c < 200; c++) begin
                    @(negedge sys_clk_i);
                    if (!seen) begin
                        if (bus.m_arready[1]) bad++;
                        if (bus.m_rvalid[0] && bus.s_rready && bus.s_rlast) begin
                            seen = 1'b1;
                            gap = 0;
                        end
                    end else begin
                        gap++;
                        if (bus.s_arvalid) break;
                    end
                end
            end
        join
        wait_done("t040");
        check("t040_m1_arready_held_low", bad, 0);
        check("t040_arvalid_gap", gap, 2);

        // single master 0 burst at 0x100
        expect_burst(0, 64'h100, 4'h1, 8'd3, 4);
        master_req(0, 64'h100, 4'h1, 8'd3);
        wait_done("t038");
        check("t038_err", err_o, 0);

        // back-pressure from master 0 toggling rready
        expect_burst(0, 64'h3800, 4'h5, 8'd3, 4);
        bad = 0;
        beats = 0;
        fork
            master_req(0, 64'h3800, 4'h5, 8'd3);
            begin
                for (int c = 0; c < 60 && beats < 4; c++) begin
                    @(posedge sys_clk_i);
                    #1 rready[0] = ~rready[0];
                    @(negedge sys_clk_i);
                    if (bus.s_rvalid && (bus.s_rready !== rready[0])) bad++;
                    if (bus.s_rvalid && bus.s_rready) beats++;
                end
            end
        join
        rready[0] = 1'b1;
        wait_done("t041");
        check("t041_rready_mirror", bad, 0);
        check("t041_beats", beats, 4);

        // early rlast on beat 2 of a 4-beat burst, then a clean burst
        early_last = 2;
        expect_burst(0, 64'h4000, 4'h4, 8'd3, 3);
        master_req(0, 64'h4000, 4'h4, 8'd3);
        wait_done("t042");
        early_last = -1;
        check("t042_err_set", err_o, 1);
        check("t042_state_idle", state_o, ST_IDLE);
        expect_burst(0, 64'h4100, 4'h6, 8'd1, 2);
        master_req(0, 64'h4100, 4'h6, 8'd1);
        wait_done("t042b");
        check("t042_err_sticky", err_o, 1);

        // reset during beat 2 of an 8-beat burst
        expect_burst(0, 64'h5000, 4'h5, 8'd7, 8);
        base = r_beats;
        master_req(0, 64'h5000, 4'h5, 8'd7);
        for (int c = 0; c < 100; c++) begin
            @(negedge sys_clk_i);
            #1;
            if (r_beats >= base + 3) break;
        end
        #1 resetn_i = 1'b0;
        #1;
        check("t043_state", state_o, ST_IDLE);
        check("t043_s_rready", bus.s_rready, 0);
        check("t043_m_rvalid", bus.m_rvalid, 0);
        check("t043_s_arvalid", bus.s_arvalid, 0);
        check("t043_m_arready", bus.m_arready, 0);
        check("t043_err_cleared", err_o, 0);
        repeat (3) @(negedge sys_clk_i);
        resetn_i = 1'b1;
        @(negedge sys_clk_i);
        check("t043_post_s_rready", bus.s_rready, 0);
        check("t043_post_m_rvalid", bus.m_rvalid, 0);
        repeat (4) @(negedge sys_clk_i);
        exp_ar_q.delete();
        exp_r_q.delete();

        expect_burst(0, 64'h6000, 4'h7, 8'd1, 2);
        expect_burst(1, 64'h7000, 4'h8, 8'd2, 3);
        fork
            master_req(0, 64'h6000, 4'h7, 8'd1);
            master_req(1, 64'h7000, 4'h8, 8'd2);
        join
        wait_done("t043b");
        check("t043b_err", err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
